// File: rtl/rram_pkg.sv
// Shared definitions for the RRAM crossbar compute-in-memory block:
// command encodings, controller states and the ADC clamp helper.
package rram_pkg;

  localparam logic [1:0] MODE_WR  = 2'b00;
  localparam logic [1:0] MODE_RD  = 2'b01;
  localparam logic [1:0] MODE_MAC = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_PRE,
    ST_SENSE,
    ST_CONV,
    ST_FIN
  } state_t;

  // Clamp a column sum to the largest code an ADC of 'bits' width can emit.
  function automatic logic [31:0] sat_adc(input logic [31:0] sum, input int unsigned bits);
    logic [31:0] lim;
    lim = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/rram_col_sum.sv
// Column dot product: sums the conductance of every cell in one bit line
// whose word line is driven by the MAC input vector.
module rram_col_sum
  import rram_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int GBITS = 2,
  parameter int SUM_W = 6
) (
  input  logic [ROWS-1:0]       i_wl,
  input  logic [ROWS*GBITS-1:0] i_col,
  output logic [SUM_W-1:0]      o_sum
);

  logic [SUM_W-1:0] w_acc;

  // Accumulate the conductances of the active word lines.
  always_comb begin
    w_acc = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (i_wl[r]) w_acc = w_acc + SUM_W'(i_col[r*GBITS +: GBITS]);
    end
  end

  assign o_sum = w_acc;

endmodule

// File: rtl/rram_xbar_cim.sv
// RRAM crossbar behavioural model with its sequencing controller:
// cell program, thresholded row read and compute-in-memory MAC whose
// column sums are digitised group by group on NADC shared ADC channels.
module rram_xbar_cim
  import rram_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int GBITS       = 2,
  parameter int NADC        = 3,
  parameter int ADC_BITS    = 16,
  parameter int PRE_CYCLES  = 2,
  parameter int WR_CYCLES   = 3,
  parameter int CONV_CYCLES = 4,
  localparam int RA_W  = $clog2(ROWS),
  localparam int CA_W  = $clog2(COLS),
  localparam int NGRP  = (COLS + NADC - 1) / NADC,
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic [1:0]               MODE,
  input  logic [RA_W-1:0]          ROW_ADDR,
  input  logic [CA_W-1:0]          COL_ADDR,
  input  logic [GBITS-1:0]         WR_DATA,
  input  logic [ROWS-1:0]          IN_WL,
  input  logic [GBITS-1:0]         CSA_THRESH,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic                     PRE,
  output logic                     SAEN_CSA,
  output logic [COLS-1:0]          CSA,
  output logic [NADC*ADC_BITS-1:0] ADC_OUT,
  output logic [NADC-1:0]          ADC_VALID,
  output logic [GRP_W-1:0]         ADC_GRP
);

  localparam int SUM_W = $clog2(ROWS * (2**GBITS - 1) + 1);
  localparam int CNT_W = 8;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [GRP_W-1:0]     r_grp;
  logic [GBITS-1:0]     r_g [ROWS][COLS];
  logic [1:0]           r_mode;
  logic [RA_W-1:0]      r_row;
  logic [CA_W-1:0]      r_col;
  logic [GBITS-1:0]     r_wdata;
  logic [ROWS-1:0]      r_wl;
  logic [GBITS-1:0]     r_thr;
  logic [SUM_W-1:0]     r_sum [COLS];

  logic [SUM_W-1:0]     w_sum [COLS];
  logic                 w_hit [NADC][NGRP];
  logic [ADC_BITS-1:0]  w_cand [NADC][NGRP];
  logic [NADC-1:0]      w_avail;
  logic [ADC_BITS-1:0]  w_adc [NADC];
  logic                 w_illegal;

  // One dot-product unit per bit line, fed from the latched input vector.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [ROWS*GBITS-1:0] w_colv;
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign w_colv[r*GBITS +: GBITS] = r_g[r][c];
    end
    rram_col_sum #(.ROWS(ROWS), .GBITS(GBITS), .SUM_W(SUM_W)) u_col_sum (
      .i_wl  (r_wl),
      .i_col (w_colv),
      .o_sum (w_sum[c])
    );
  end

  // Saturated candidate per (channel, group); padding columns of the
  // partial last group never exist, so those channels stay silent.
  for (genvar k = 0; k < NADC; k++) begin : g_ch
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      if (g * NADC + k < COLS) begin : g_live
        logic [31:0] w_sat;
        assign w_sat        = sat_adc(32'(r_sum[g*NADC+k]), ADC_BITS);
        assign w_hit[k][g]  = 1'b1;
        assign w_cand[k][g] = ADC_BITS'(w_sat);
      end else begin : g_pad
        assign w_hit[k][g]  = 1'b0;
        assign w_cand[k][g] = '0;
      end
    end
  end

  // Select each channel's conversion result for the group in flight.
  always_comb begin
    for (int k = 0; k < NADC; k++) begin
      w_avail[k] = 1'b0;
      w_adc[k]   = '0;
      for (int g = 0; g < NGRP; g++) begin
        if (r_grp == GRP_W'(g) && w_hit[k][g]) begin
          w_avail[k] = 1'b1;
          w_adc[k]   = w_cand[k][g];
        end
      end
    end
  end

  assign w_illegal = (r_mode == MODE_RSV) ||
                     (r_mode != MODE_MAC && int'(r_row) >= ROWS) ||
                     (r_mode == MODE_WR  && int'(r_col) >= COLS);

  // Command operands and column sums: captured once, held for the operation.
  always_ff @(posedge CLK) begin
    if (r_state == ST_IDLE && START) begin
      r_mode  <= MODE;
      r_row   <= ROW_ADDR;
      r_col   <= COL_ADDR;
      r_wdata <= WR_DATA;
      r_wl    <= IN_WL;
      r_thr   <= CSA_THRESH;
    end
    if (r_state == ST_SENSE) begin
      for (int c = 0; c < COLS; c++) r_sum[c] <= w_sum[c];
    end
  end

  // Sequencing controller, array state and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_grp     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      PRE       <= 1'b0;
      SAEN_CSA  <= 1'b0;
      CSA       <= '0;
      ADC_OUT   <= '0;
      ADC_VALID <= '0;
      ADC_GRP   <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) r_g[r][c] <= '0;
      end
    end else begin
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      SAEN_CSA  <= 1'b0;
      ADC_VALID <= '0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_state <= ST_CHECK;
            BUSY    <= 1'b1;
          end
        end
        ST_CHECK: begin
          r_cnt <= '0;
          if (w_illegal) begin
            r_state <= ST_FIN;
            DONE    <= 1'b1;
            ERR     <= 1'b1;
          end else if (r_mode == MODE_WR) begin
            r_state <= ST_WRITE;
          end else begin
            r_state <= ST_PRE;
            PRE     <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (r_cnt == CNT_W'(WR_CYCLES - 1)) begin
            r_g[r_row][r_col] <= r_wdata;
            r_state           <= ST_FIN;
            DONE              <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PRE: begin
          if (r_cnt == CNT_W'(PRE_CYCLES - 1)) begin
            PRE      <= 1'b0;
            SAEN_CSA <= 1'b1;
            r_state  <= ST_SENSE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SENSE: begin
          r_cnt <= '0;
          r_grp <= '0;
          if (r_mode == MODE_RD) begin
            for (int c = 0; c < COLS; c++) CSA[c] <= (r_g[r_row][c] >= r_thr);
            r_state <= ST_FIN;
            DONE    <= 1'b1;
          end else begin
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (r_cnt == CNT_W'(CONV_CYCLES - 1)) begin
            for (int k = 0; k < NADC; k++) begin
              if (w_avail[k]) ADC_OUT[k*ADC_BITS +: ADC_BITS] <= w_adc[k];
            end
            ADC_VALID <= w_avail;
            ADC_GRP   <= r_grp;
            r_cnt     <= '0;
            if (r_grp == GRP_W'(NGRP - 1)) begin
              r_state <= ST_FIN;
              DONE    <= 1'b1;
            end else begin
              r_grp <= r_grp + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          BUSY    <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
